// File: rtl/dir_validator.sv
// dir_validator: walks one direction of the board from a candidate move,
// counts opponent discs until a terminating cell, and reports whether the
// direction captures anything. The board RAM has a one-cycle read latency.
module dir_validator #(
  parameter int CELLS = 100,
  parameter int AW    = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          ld,
  input  logic [4:0]    step_in,
  input  logic          step_sign_in,
  input  logic [AW-1:0] pos_in,
  input  logic          player_in,
  output logic [AW-1:0] mem_addr_o,
  input  logic [1:0]    mem_data_i,
  output logic          s_done_o,
  output logic          dir_status_o,
  output logic [3:0]    flip_cnt_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_ORIGIN = 3'd1;
  localparam logic [2:0] EV_ORIGIN = 3'd2;
  localparam logic [2:0] RD_NEXT   = 3'd3;
  localparam logic [2:0] EV_NEXT   = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  // One extra bit so that both underflow and overflow of cur +/- step are visible.
  localparam int            SW       = AW + 1;
  localparam logic [SW-1:0] MAX_ADDR = SW'(CELLS - 1);
  localparam logic [3:0]    CNT_MAX  = 4'd8;
  localparam logic [1:0]    CELL_EMPTY = 2'b00;

  logic [2:0]    state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic          sign_q, sign_d;
  logic [AW-1:0] pos_q, pos_d;
  logic          player_q, player_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          status_q, status_d;
  logic [3:0]    flip_q, flip_d;

  logic [1:0]    ownColour, oppColour;
  logic [SW-1:0] curWide, stepWide, sumWide;
  logic          stepOutOfRange;
  logic [AW-1:0] nextCur;

  assign ownColour = player_q ? 2'b10 : 2'b01;
  assign oppColour = player_q ? 2'b01 : 2'b10;
  assign curWide   = {1'b0, cur_q};
  assign stepWide  = SW'(step_q);
  assign nextCur   = sumWide[AW-1:0];

  // Next address along the direction, flagged when it leaves the board array.
  always_comb begin
    sumWide        = '0;
    stepOutOfRange = 1'b0;
    if (sign_q) begin
      sumWide        = curWide - stepWide;
      stepOutOfRange = (stepWide > curWide);
    end else begin
      sumWide        = curWide + stepWide;
      stepOutOfRange = (sumWide > MAX_ADDR);
    end
  end

  // Walk controller: read a cell, evaluate it one cycle later, repeat until a terminator.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    sign_d   = sign_q;
    pos_d    = pos_q;
    player_d = player_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    status_d = status_q;
    flip_d   = flip_q;

    case (state_q)
      IDLE: begin
        if (ld) begin
          step_d   = step_in;
          sign_d   = step_sign_in;
          pos_d    = pos_in;
          player_d = player_in;
        end
        if (enable) begin
          cur_d   = ld ? pos_in : pos_q;
          addr_d  = ld ? pos_in : pos_q;
          cnt_d   = '0;
          state_d = RD_ORIGIN;
        end
      end
      RD_ORIGIN: state_d = EV_ORIGIN;
      EV_ORIGIN: begin
        if (mem_data_i != CELL_EMPTY || stepOutOfRange) begin
          status_d = 1'b0;
          flip_d   = '0;
          state_d  = DONE;
        end else begin
          cur_d   = nextCur;
          addr_d  = nextCur;
          state_d = RD_NEXT;
        end
      end
      RD_NEXT: state_d = EV_NEXT;
      EV_NEXT: begin
        if (mem_data_i == oppColour) begin
          if (cnt_q == CNT_MAX || stepOutOfRange) begin
            status_d = 1'b0;
            flip_d   = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            cur_d   = nextCur;
            addr_d  = nextCur;
            state_d = RD_NEXT;
          end
        end else if (mem_data_i == ownColour) begin
          status_d = (cnt_q != 4'd0);
          flip_d   = cnt_q;
          state_d  = DONE;
        end else begin
          status_d = 1'b0;
          flip_d   = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      sign_q   <= 1'b0;
      pos_q    <= '0;
      player_q <= 1'b0;
      cur_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      status_q <= 1'b0;
      flip_q   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      sign_q   <= sign_d;
      pos_q    <= pos_d;
      player_q <= player_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      flip_q   <= flip_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign s_done_o     = (state_q == DONE);
  assign dir_status_o = status_q;
  assign flip_cnt_o   = flip_q;

endmodule

// File: tb/tb_dir_validator.sv
// Testbench for dir_validator: builds a board model around each candidate
// move, runs a table of directed vectors, then covers restart and reset corners.
module tb_dir_validator;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       ld;
  logic [4:0] step_in;
  logic       step_sign_in;
  logic [6:0] pos_in;
  logic       player_in;
  logic [6:0] mem_addr_o;
  logic [1:0] mem_data_i;
  logic       s_done_o;
  logic       dir_status_o;
  logic [3:0] flip_cnt_o;

  int nChecks = 0;
  int nFails  = 0;

  logic [1:0] board [0:127];
  int         readLog[$];

  typedef struct {
    int         pos;
    int         step;
    bit         sign;
    bit         player;
    logic [1:0] originVal;
    int         k;
    logic [1:0] termVal;
    bit         sepLd;
    int         expCyc;
    bit         expStat;
    int         expFlip;
  } vec_t;

  vec_t vecs[14];

  dir_validator #(.CELLS(100), .AW(7)) dut (
    .clock(clock), .reset(reset), .enable(enable), .ld(ld),
    .step_in(step_in), .step_sign_in(step_sign_in), .pos_in(pos_in),
    .player_in(player_in), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
    .s_done_o(s_done_o), .dir_status_o(dir_status_o), .flip_cnt_o(flip_cnt_o)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Board RAM model with one-cycle read latency.
  always @(posedge clock) mem_data_i <= board[mem_addr_o];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Bordered empty board, then origin, k opponent discs and a terminator along the line.
  task automatic setupBoard(input vec_t v);
    int dir, a;
    logic [1:0] opp;
    for (int i = 0; i < 128; i++) begin
      if (i >= 100) board[i] = 2'b11;
      else if (i / 10 == 0 || i / 10 == 9 || i % 10 == 0 || i % 10 == 9) board[i] = 2'b11;
      else board[i] = 2'b00;
    end
    dir = v.sign ? -1 : 1;
    opp = v.player ? 2'b01 : 2'b10;
    board[v.pos] = v.originVal;
    for (int j = 1; j <= v.k; j++) begin
      a = v.pos + dir * j * v.step;
      if (a >= 0 && a <= 99) board[a] = opp;
    end
    a = v.pos + dir * (v.k + 1) * v.step;
    if (a >= 0 && a <= 99) board[a] = v.termVal;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    step_in      = 5'(v.step);
    step_sign_in = v.sign;
    pos_in       = 7'(v.pos);
    player_in    = v.player;
    ld           = 1'b1;
    enable       = v.sepLd ? 1'b0 : 1'b1;
    if (v.sepLd) begin
      @(negedge clock);
      step_in      = 5'd3;
      step_sign_in = ~v.sign;
      pos_in       = 7'd77;
      player_in    = ~v.player;
      ld           = 1'b0;
      enable       = 1'b1;
    end
  endtask

  // Waits for s_done_o, logging distinct read addresses; returns cycle (0 = timeout).
  task automatic waitDone(output int doneCyc);
    doneCyc = 0;
    readLog.delete();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        enable = 1'b0;
        ld     = 1'b0;
      end
      if (readLog.size() == 0 || readLog[$] != int'(mem_addr_o)) readLog.push_back(int'(mem_addr_o));
      if (s_done_o) begin
        doneCyc = cyc;
        break;
      end
    end
  endtask

  task automatic runVector(input int idx, input vec_t v);
    int doneCyc, nReads, badIdx, dir;
    setupBoard(v);
    applyStimulus(v);
    waitDone(doneCyc);
    checkOutput($sformatf("v%0d done cycle", idx), doneCyc, v.expCyc);
    checkOutput($sformatf("v%0d dir_status", idx), int'(dir_status_o), int'(v.expStat));
    checkOutput($sformatf("v%0d flip_cnt", idx), int'(flip_cnt_o), v.expFlip);
    nReads = (v.expCyc - 1) / 2;
    checkOutput($sformatf("v%0d read count", idx), readLog.size(), nReads);
    dir = v.sign ? -1 : 1;
    badIdx = -1;
    for (int i = 0; i < readLog.size() && i < nReads; i++)
      if (badIdx < 0 && readLog[i] != v.pos + dir * i * v.step) badIdx = i;
    checkOutput($sformatf("v%0d read order bad index", idx), badIdx, -1);
    @(negedge clock);
    checkOutput($sformatf("v%0d done pulse width", idx), int'(s_done_o), 0);
    checkOutput($sformatf("v%0d status hold", idx), int'(dir_status_o), int'(v.expStat));
  endtask

  initial begin
    int doneCyc, pulses;
    vec_t v;

    //          pos step sign pl  orig   k  term  sepLd cyc st flip
    vecs[0]  = '{34, 1,  0, 0, 2'b00, 1, 2'b01, 0,  7, 1, 1};
    vecs[1]  = '{34, 1,  0, 0, 2'b01, 0, 2'b00, 0,  3, 0, 0};
    vecs[2]  = '{54, 10, 1, 1, 2'b00, 3, 2'b10, 1, 11, 1, 3};
    vecs[3]  = '{34, 1,  0, 0, 2'b00, 4, 2'b11, 0, 13, 0, 0};
    vecs[4]  = '{34, 1,  0, 0, 2'b00, 0, 2'b01, 0,  5, 0, 0};
    vecs[5]  = '{5,  10, 1, 0, 2'b00, 0, 2'b01, 0,  3, 0, 0};
    vecs[6]  = '{44, 1,  0, 1, 2'b00, 0, 2'b00, 1,  5, 0, 0};
    vecs[7]  = '{23, 10, 0, 1, 2'b00, 2, 2'b10, 0,  9, 1, 2};
    vecs[8]  = '{95, 10, 0, 0, 2'b00, 0, 2'b01, 0,  3, 0, 0};
    vecs[9]  = '{89, 10, 0, 0, 2'b00, 0, 2'b11, 0,  5, 0, 0};
    vecs[10] = '{0,  1,  0, 0, 2'b00, 8, 2'b01, 0, 21, 1, 8};
    vecs[11] = '{0,  1,  0, 1, 2'b00, 9, 2'b10, 0, 21, 0, 0};
    vecs[12] = '{98, 1,  1, 1, 2'b00, 1, 2'b10, 1,  7, 1, 1};
    vecs[13] = '{11, 1,  1, 0, 2'b00, 0, 2'b11, 0,  5, 0, 0};

    reset = 1'b0; enable = 1'b0; ld = 1'b0;
    step_in = 5'd0; step_sign_in = 1'b0; pos_in = 7'd0; player_in = 1'b0;
    setupBoard(vecs[0]);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset s_done", int'(s_done_o), 0);
    checkOutput("reset dir_status", int'(dir_status_o), 0);
    checkOutput("reset flip_cnt", int'(flip_cnt_o), 0);
    checkOutput("reset mem_addr", int'(mem_addr_o), 0);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) runVector(i, vecs[i]);

    // enable and ld pulsed mid-run must not restart or reload the walk
    v = vecs[0];
    setupBoard(v);
    applyStimulus(v);
    doneCyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin enable = 1'b0; ld = 1'b0; end
      if (cyc == 2) begin
        enable = 1'b1; ld = 1'b1; pos_in = 7'd77; step_in = 5'd3;
        step_sign_in = 1'b1; player_in = 1'b1;
      end
      if (cyc == 3) begin enable = 1'b0; ld = 1'b0; end
      if (s_done_o) begin doneCyc = cyc; break; end
    end
    checkOutput("midrun enable done cycle", doneCyc, 7);
    checkOutput("midrun enable dir_status", int'(dir_status_o), 1);
    checkOutput("midrun enable flip_cnt", int'(flip_cnt_o), 1);
    pulses = 0;
    repeat (12) begin
      @(negedge clock);
      if (s_done_o) pulses++;
    end
    checkOutput("midrun enable extra pulses", pulses, 0);

    // reset asserted mid-run aborts without a completion pulse
    v = vecs[3];
    setupBoard(v);
    applyStimulus(v);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin enable = 1'b0; ld = 1'b0; end
    end
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrun reset s_done", int'(s_done_o), 0);
    checkOutput("midrun reset dir_status", int'(dir_status_o), 0);
    checkOutput("midrun reset flip_cnt", int'(flip_cnt_o), 0);
    checkOutput("midrun reset mem_addr", int'(mem_addr_o), 0);
    reset = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clock);
      if (s_done_o) pulses++;
    end
    checkOutput("midrun reset stray pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
